fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the LoongArch32 five-stage pipeline.
- Generates fetch PCs (pre-IF) and issues requests on the SRAM-like instruction bus.
- Holds one instruction, delivers {inst, pc} to ID over fs_to_ds_valid / ds_allowin, and consumes ID's branch redirect bus.
- Cancels wrong-path fetches, including responses still outstanding on the bus.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
ds_allowin  input  1  ID can accept an instruction this cycle
br_bus  input  `BR_BUS_WD (33)  {br_taken[32], br_target[31:0]}; level signal, may hold for several cycles
fs_to_ds_valid  output  1  fs_to_ds_bus valid
fs_to_ds_bus  output  `FS_TO_DS_BUS_WD (64)  {inst[63:32], pc[31:0]}
inst_sram_req  output  1  fetch request
inst_sram_addr  output  32  request address
inst_sram_addr_ok  input  1  address accepted
inst_sram_data_ok  input  1  read data returned (in order)
inst_sram_rdata  input  32  instruction word

Behaviour:
- State: started, pf_pc[31:0], fs_valid, fs_pc[31:0], fs_inst_valid, fs_inst[31:0], drop (1 bit).
- Reset (async, reset=0) values:
  - started=0, pf_pc=RESET_PC; all other state 0.
  - Outputs: inst_sram_req=0, fs_to_ds_valid=0.
  - inst_sram_addr=RESET_PC, fs_to_ds_bus=0 (inst=rdata only when no inst buffered; defined as 0 while fs_valid=0).
- started becomes 1 on the first clk edge after reset release. No request before that.
- fs_ready_go = fs_inst_valid | (inst_sram_data_ok & ~drop).
- fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
- inst_sram_req = started & ~br_taken & ~drop & fs_allowin.
- inst_sram_addr = pf_pc.
- Address handshake (req & addr_ok): fs_valid←1, fs_pc←pf_pc, pf_pc←pf_pc+4 (mod 2^32, wraps), fs_inst_valid←0.
- Data return:
  - data_ok & drop: drop←0, data discarded.
  - data_ok & ~drop & fs_valid & ~(ds_allowin & ~br_taken): fs_inst←rdata, fs_inst_valid←1.
- fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.
- fs_to_ds_bus = {fs_inst_valid ? fs_inst : inst_sram_rdata, fs_pc}.
- Hand-off to ID (fs_to_ds_valid & ds_allowin) with no new handshake: fs_valid←0, fs_inst_valid←0.
- Redirect (br_taken=1, any cycle):
  - No request issued.
  - pf_pc←br_target.
  - fs_valid←0, fs_inst_valid←0.
  - If fs_valid & ~fs_inst_valid & ~data_ok this cycle: drop←1, so the pending response is discarded.
  - Repeated br_taken cycles are idempotent.
  - Fetch of br_target starts in the first cycle br_taken=0.
- At most one outstanding bus transaction: req is gated by fs_allowin and drop.
- Simultaneous data_ok and br_taken: data discarded, drop stays 0.
- Simultaneous hand-off and new handshake: new pc replaces old, back-to-back throughput of 1 inst/cycle.
- inst_sram_req stays asserted (addr stable) until addr_ok, unless br_taken rises. In that case req drops and addr changes; the bus tolerates request withdrawal.
- Reset mid-operation clears all state immediately. The instruction SRAM is reset concurrently, so no stale data_ok is expected.
- Latency: pc visible to ID one cycle after data_ok, or combinationally in the data_ok cycle when ds_allowin=1.

Optional Feature:
- FS_STAT_EN defined:
  - Adds output port fs_drop_cnt[31:0], reset 0.
  - Increments (wrapping) on every discarded response: data_ok&drop, or data_ok coincident with br_taken.
- FS_STAT_EN undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, addr_ok=data_ok=1 each following cycle, ds_allowin=1 → requests 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles; ID receives one inst/cycle with matching pc.
- ds_allowin=0 for 3 cycles after data_ok for pc 0x1c000000 → fs_inst holds rdata, fs_to_ds_valid=1 held, no new req; on ds_allowin=1 → delivered, req for 0x1c000004 same cycle.
- br_bus={1,0x1c000100} while fs holds undelivered pc 0x1c000008 with data outstanding → fs_to_ds_valid=0, drop=1, next data_ok discarded, next request addr 0x1c000100.
- br_taken held 4 cycles → no req during those cycles, single fetch of target after release, target delivered with pc=br_target.
- addr_ok=0 for 5 cycles → req and addr 0x1c000000 stable; async reset asserted mid-wait → req=0 immediately, restart at RESET_PC.
- FS_STAT_EN: two cancelled in-flight fetches → fs_drop_cnt=2; pf_pc=0xfffffffc sequential → next pc 0x00000000.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: LoongArch32 IF stage, pre-IF pc generation and SRAM-like fetch.
// Define FS_STAT_EN to add fs_drop_cnt, a wrapping count of discarded responses.
`ifndef BR_BUS_WD
`define BR_BUS_WD 33
`endif
`ifndef FS_TO_DS_BUS_WD
`define FS_TO_DS_BUS_WD 64
`endif

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ds_allowin,
  input  logic [`BR_BUS_WD-1:0]       br_bus,
  output logic                        fs_to_ds_valid,
  output logic [`FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                        inst_sram_req,
  output logic [31:0]                 inst_sram_addr,
  input  logic                        inst_sram_addr_ok,
  input  logic                        inst_sram_data_ok,
  input  logic [31:0]                 inst_sram_rdata
`ifdef FS_STAT_EN
  ,
  output logic [31:0]                 fs_drop_cnt
`endif
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;

  logic        started;
  logic [31:0] pf_pc;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        fs_inst_valid;
  logic [31:0] fs_inst;
  logic        drop;

  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        addr_hs;
  logic        hand_off;
  logic        data_keep;
  logic        data_toss;
  if_id_t      ds_bus;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  assign fs_ready_go = fs_inst_valid
                     | (inst_sram_data_ok & ~drop);
  assign fs_allowin  = ~fs_valid
                     | (fs_ready_go & ds_allowin);

  assign inst_sram_req  = started & ~br_taken
                        & ~drop & fs_allowin;
  assign inst_sram_addr = pf_pc;

  assign addr_hs  = inst_sram_req & inst_sram_addr_ok;
  assign hand_off = fs_to_ds_valid & ds_allowin;

  // Buffer the word only when ID cannot take it in its arrival cycle.
  assign data_keep = inst_sram_data_ok & ~drop & fs_valid
                   & ~(ds_allowin & ~br_taken);

  assign data_toss = inst_sram_data_ok
                   & (drop | br_taken);

  assign fs_to_ds_valid = fs_valid & fs_ready_go
                        & ~br_taken;

  always_comb begin
    ds_bus = '0;
    if (fs_valid) begin
      ds_bus.inst = fs_inst_valid ? fs_inst
                                  : inst_sram_rdata;
      ds_bus.pc   = fs_pc;
    end
  end

  assign fs_to_ds_bus = ds_bus;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_pc <= RESET_PC;
    end else if (br_taken) begin
      pf_pc <= br_target;
    end else if (addr_hs) begin
      pf_pc <= pf_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_valid <= 1'b0;
    end else if (br_taken) begin
      fs_valid <= 1'b0;
    end else if (addr_hs) begin
      fs_valid <= 1'b1;
    end else if (hand_off) begin
      fs_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_pc <= 32'd0;
    end else if (addr_hs) begin
      fs_pc <= pf_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_inst_valid <= 1'b0;
    end else if (br_taken | addr_hs | hand_off) begin
      fs_inst_valid <= 1'b0;
    end else if (data_keep) begin
      fs_inst_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_inst <= 32'd0;
    end else if (data_keep) begin
      fs_inst <= inst_sram_rdata;
    end
  end

  // A redirect with a response still in flight must swallow that response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop <= 1'b0;
    end else if (inst_sram_data_ok & drop) begin
      drop <= 1'b0;
    end else if (br_taken & fs_valid & ~fs_inst_valid
                 & ~inst_sram_data_ok) begin
      drop <= 1'b1;
    end
  end

`ifdef FS_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_drop_cnt <= 32'd0;
    end else if (data_toss) begin
      fs_drop_cnt <= fs_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_toss;
  assign unused_toss = data_toss;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scripted bench for fetch_stage with an SRAM model
// and a scoreboard of expected {inst, pc} deliveries to ID.
`timescale 1ns/1ps

module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ds_allowin = 1'b0;
  logic [32:0] br_bus = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;
`ifdef FS_STAT_EN
  logic [31:0] fs_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic        addr_ok_en = 1'b0;
  logic        data_ok_en = 1'b0;
  logic [31:0] pend[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (req),
    .inst_sram_addr    (addr),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata)
`ifdef FS_STAT_EN
    ,
    .fs_drop_cnt       (fs_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction

  // SRAM model: in-order, one response per accepted address.
  always @(posedge clk) begin
    #2;
    addr_ok = addr_ok_en;
    if (data_ok_en && pend.size() > 0) begin
      data_ok = 1'b1;
      rdata   = inst_of(pend[0]);
    end else begin
      data_ok = 1'b0;
      rdata   = 32'h0bad_f00d;
    end
  end

  // Scoreboard: accepted address -> expected delivery; redirect kills all.
  always @(negedge clk) begin
    if (reset) begin
      if (data_ok && pend.size() > 0) void'(pend.pop_front());
      if (fs_to_ds_valid && ds_allowin) begin
        checks++;
        delivered++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deliver: got %h, required no delivery",
                   fs_to_ds_bus);
        end else begin
          exp_e = exp_q.pop_front();
          if (fs_to_ds_bus !== exp_e) begin
            errors++;
            $display("FAIL deliver: got %h, required %h",
                     fs_to_ds_bus, exp_e);
          end
        end
      end
      if (br_bus[32]) exp_q.delete();
      if (req && addr_ok) begin
        pend.push_back(addr);
        exp_q.push_back({inst_of(addr), addr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ds_allowin = 1'b0;
    br_bus = '0;
    addr_ok_en = 1'b0;
    data_ok_en = 1'b0;
    pend.delete();
    exp_q.delete();
    delivered = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: req=%b valid=%b, required 0 0",
               req, fs_to_ds_valid);
    end
    checks++;
    if (addr !== RPC) begin
      errors++;
      $display("FAIL reset_addr: got %h, required %h", addr, RPC);
    end
    checks++;
    if (fs_to_ds_bus !== 64'd0) begin
      errors++;
      $display("FAIL reset_bus: got %h, required 0", fs_to_ds_bus);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL not_started: req=%b, required 0", req);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== RPC) begin
      errors++;
      $display("FAIL started: req=%b addr=%h, required 1 %h",
               req, addr, RPC);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    #1;
    ds_allowin = 1'b1;
    addr_ok_en = 1'b1;
    data_ok_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b1 || addr !== RPC + 32'(4 * i)) begin
        errors++;
        $display("FAIL b2b_addr[%0d]: req=%b addr=%h, required 1 %h",
                 i, req, addr, RPC + 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if (fs_to_ds_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_valid[%0d]: got %b, required 1",
                   i, fs_to_ds_valid);
        end
      end
      @(posedge clk);
    end
    #1 addr_ok_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (delivered !== 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: delivered=%0d left=%0d, required 6 0",
               delivered, exp_q.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    #1;
    ds_allowin = 1'b1;
    addr_ok_en = 1'b1;
    data_ok_en = 1'b1;
    @(negedge clk);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      #1 ds_allowin = 1'b0;
      @(negedge clk);
      checks++;
      if (req !== 1'b0 || fs_to_ds_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_ctl[%0d]: req=%b valid=%b, required 0 1",
                 k, req, fs_to_ds_valid);
      end
      checks++;
      if (fs_to_ds_bus !== {inst_of(RPC), RPC}) begin
        errors++;
        $display("FAIL stall_bus[%0d]: got %h, required %h",
                 k, fs_to_ds_bus, {inst_of(RPC), RPC});
      end
      @(posedge clk);
    end
    #1 ds_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== RPC + 32'd4
        || fs_to_ds_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b, required 1 %h 1",
               req, addr, fs_to_ds_valid, RPC + 32'd4);
    end
    @(posedge clk);
    #1 addr_ok_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (delivered !== 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: delivered=%0d left=%0d, required 2 0",
               delivered, exp_q.size());
    end
  endtask

  task automatic test_branch_cancel();
    do_reset();
    #1;
    ds_allowin = 1'b1;
    addr_ok_en = 1'b1;
    data_ok_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      @(posedge clk);
    end
    #1;
    data_ok_en = 1'b0;
    br_bus = {1'b1, 32'h1c000100};
    @(negedge clk);
    checks++;
    if (req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_cycle: req=%b valid=%b, required 0 0",
               req, fs_to_ds_valid);
    end
    @(posedge clk);
    #1;
    br_bus = '0;
    data_ok_en = 1'b1;
    @(negedge clk);
    checks++;
    if (req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_drop: req=%b valid=%b, required 0 0",
               req, fs_to_ds_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== 32'h1c000100) begin
      errors++;
      $display("FAIL br_target: req=%b addr=%h, required 1 1c000100",
               req, addr);
    end
    @(posedge clk);
    #1 addr_ok_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (delivered !== 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL br_count: delivered=%0d left=%0d, required 3 0",
               delivered, exp_q.size());
    end
  endtask

  task automatic test_branch_hold();
    do_reset();
    #1;
    ds_allowin = 1'b1;
    addr_ok_en = 1'b1;
    data_ok_en = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 br_bus = {1'b1, 32'h1c000200};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_ctl[%0d]: req=%b valid=%b, required 0 0",
                 k, req, fs_to_ds_valid);
      end
      @(posedge clk);
    end
    #1 br_bus = '0;
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== 32'h1c000200) begin
      errors++;
      $display("FAIL hold_target: req=%b addr=%h, required 1 1c000200",
               req, addr);
    end
    @(posedge clk);
    #1 addr_ok_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (delivered !== 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_count: delivered=%0d left=%0d, required 2 0",
               delivered, exp_q.size());
    end
  endtask

  task automatic test_addr_wait_reset();
    do_reset();
    #1;
    ds_allowin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b1 || addr !== RPC) begin
        errors++;
        $display("FAIL wait_hold[%0d]: req=%b addr=%h, required 1 %h",
                 k, req, addr, RPC);
      end
      @(posedge clk);
    end
    #3 reset = 1'b0;
    pend.delete();
    exp_q.delete();
    delivered = 0;
    #1;
    checks++;
    if (req !== 1'b0 || fs_to_ds_valid !== 1'b0 || addr !== RPC) begin
      errors++;
      $display("FAIL async_rst: req=%b valid=%b addr=%h, required 0 0 %h",
               req, fs_to_ds_valid, addr, RPC);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    addr_ok_en = 1'b1;
    data_ok_en = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== RPC) begin
      errors++;
      $display("FAIL restart: req=%b addr=%h, required 1 %h",
               req, addr, RPC);
    end
    @(posedge clk);
    #1 addr_ok_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (delivered !== 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_count: delivered=%0d left=%0d, required 1 0",
               delivered, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    #1 br_bus = {1'b1, 32'hfffffffc};
    @(negedge clk);
    @(posedge clk);
    #1;
    br_bus = '0;
    ds_allowin = 1'b1;
    addr_ok_en = 1'b1;
    data_ok_en = 1'b1;
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== 32'hfffffffc) begin
      errors++;
      $display("FAIL wrap_first: req=%b addr=%h, required 1 fffffffc",
               req, addr);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== 32'h00000000) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h, required 1 00000000",
               req, addr);
    end
    @(posedge clk);
    #1 addr_ok_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (delivered !== 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count: delivered=%0d left=%0d, required 2 0",
               delivered, exp_q.size());
    end
  endtask

`ifdef FS_STAT_EN
  task automatic test_stat();
    do_reset();
    #1;
    ds_allowin = 1'b1;
    addr_ok_en = 1'b1;
    data_ok_en = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      addr_ok_en = 1'b0;
      br_bus = {1'b1, 32'h1c000040 + 32'(n * 64)};
      @(negedge clk);
      @(posedge clk);
      #1;
      br_bus = '0;
      data_ok_en = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      data_ok_en = 1'b0;
      addr_ok_en = 1'b1;
    end
    addr_ok_en = 1'b0;
    @(negedge clk);
    checks++;
    if (fs_drop_cnt !== 32'd2 || delivered !== 0) begin
      errors++;
      $display("FAIL stat_cnt: cnt=%0d delivered=%0d, required 2 0",
               fs_drop_cnt, delivered);
    end
    @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_branch_cancel();
    test_branch_hold();
    test_addr_wait_reset();
    test_wrap();
`ifdef FS_STAT_EN
    test_stat();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
